// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic column drain block.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_t;

  function automatic int float_width(input int expW, input int fracW);
    return expW + fracW + 1;
  endfunction

endpackage

// File: rtl/systolic_col_drain_if.sv
// Valid/ready result stream leaving the column drain, with a last-word flag.
interface systolic_col_drain_if #(
  parameter int W = 14
);

  logic [W-1:0] outData;
  logic         outValid;
  logic         outReady;
  logic         outLast;

  modport master (
    output outData,
    output outValid,
    output outLast,
    input  outReady
  );

  modport slave (
    input  outData,
    input  outValid,
    input  outLast,
    output outReady
  );

endinterface

// File: rtl/systolic_col_drain_fifo.sv
// Capture FIFO for the column drain; each entry holds {last, data} and the head is read from the array.
module drain_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr_q] <= pushData;
  end

  assign popData = mem[rdPtr_q];
  assign count   = count_q;

endmodule

// File: rtl/systolic_col_drain.sv
// Result drain for one systolic column: shifts accumulators out of the bottom PE into a FIFO and streams them.
// Optional stall counter output enabled by defining SYSTOLIC_DRAIN_STALL_CNT_EN.
module systolic_col_drain
  import systolic_pkg::*;
#(
  parameter int EXP_OUT    = 5,
  parameter int FRAC_OUT   = 8,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int W = float_width(EXP_OUT, FRAC_OUT)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] colIn,
  output logic         enableShiftOut,
  output logic [W-1:0] topCIn,
  output logic         busy,
  output logic         done,
`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
  output logic [15:0]  stallCycles,
`endif
  systolic_col_drain_if.master outStream
);

  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  drain_state_t      state_q;
  logic [CNT_W-1:0]  capCnt_q;
  logic              done_q;
  logic [FCNT_W-1:0] fifoCount;
  logic [W:0]        headWord;
  logic              push;
  logic              pop;
  logic              lastTag;
  logic              fifoFull;

  // Shift enable depends only on registered state so outReady never reaches the PEs combinationally.
  assign fifoFull       = (fifoCount == FCNT_W'(FIFO_DEPTH));
  assign enableShiftOut = (state_q == DRAIN) && !fifoFull;
  assign push           = enableShiftOut;
  assign lastTag        = (capCnt_q == CNT_W'(ROWS - 1));
  assign pop            = outStream.outValid && outStream.outReady;

  assign topCIn             = '0;
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign outStream.outValid = (fifoCount != '0);
  assign outStream.outData  = outStream.outValid ? headWord[W-1:0] : '0;
  assign outStream.outLast  = outStream.outValid && headWord[W];

  drain_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData ({lastTag, colIn}),
    .pop      (pop),
    .popData  (headWord),
    .count    (fifoCount)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      capCnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= DRAIN;
            capCnt_q <= '0;
          end
        end
        DRAIN: begin
          if (push) begin
            capCnt_q <= capCnt_q + CNT_W'(1);
            if (lastTag) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && fifoCount == FCNT_W'(1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == DRAIN && fifoFull && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_systolic_col_drain.sv
// Self-checking bench for systolic_col_drain: queue-based drain model, PE column model and directed scenarios.
module tb_systolic_col_drain;
  import systolic_pkg::*;

  localparam int ROWS  = 8;
  localparam int DEPTH = 4;
  localparam int W     = float_width(5, 8);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         readyDrv = 1'b0;
  logic [W-1:0] colIn;
  logic         enableShiftOut;
  logic [W-1:0] topCIn;
  logic         busy;
  logic         done;
`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
  logic [15:0]  stallCycles;
`endif

  systolic_col_drain_if #(.W(W)) outStream ();
  assign outStream.outReady = readyDrv;

  systolic_col_drain #(
    .EXP_OUT    (5),
    .FRAC_OUT   (8),
    .ROWS       (ROWS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .colIn          (colIn),
    .enableShiftOut (enableShiftOut),
    .topCIn         (topCIn),
    .busy           (busy),
    .done           (done),
`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
    .stallCycles    (stallCycles),
`endif
    .outStream      (outStream)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // PE column model: col[0] is the bottom PE feeding colIn.
  logic [W-1:0] col [ROWS];
  assign colIn = col[0];
  bit shiftPending;

  // Drain model: words in flight, pushes so far, busy/done and stall count.
  logic [W:0] mQ[$];
  bit         mBusy, mDone;
  int         mPushed, mStall;
  bit         checkOn;

  logic [W:0]   rxQ[$];
  int           cyc, doneCount, doneCycle, shiftCount, firstShift, lastShift, startCyc;
  logic [W-1:0] prevData;
  bit           prevStall;
  bit           expEn, expValid, popM, newDone, wasBusy;
  logic [W:0]   head;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    #1;
    if (shiftPending) begin
      for (int i = 0; i < ROWS - 1; i++) col[i] = col[i+1];
      col[ROWS-1]  = topCIn;
      shiftPending = 0;
    end
  end

  // Compare DUT against the model, record the stream, then advance the model across the next edge.
  always @(negedge clock) begin
    if (checkOn && !reset) begin
      expValid = (mQ.size() > 0);
      head     = expValid ? mQ[0] : '0;
      expEn    = mBusy && (mPushed < ROWS) && (mQ.size() < DEPTH);
      checkOutput("enableShiftOut", 32'(enableShiftOut), 32'(expEn));
      checkOutput("outValid", 32'(outStream.outValid), 32'(expValid));
      checkOutput("outData", 32'(outStream.outData), 32'(head[W-1:0]));
      checkOutput("outLast", 32'(outStream.outLast), 32'(head[W]));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("topCIn", 32'(topCIn), 32'd0);
`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
      checkOutput("stallCycles", 32'(stallCycles), 32'(mStall));
`endif
      if (prevStall) checkOutput("outDataHold", 32'(outStream.outData), 32'(prevData));
      prevStall = outStream.outValid && !readyDrv;
      prevData  = outStream.outData;

      if (enableShiftOut) begin
        shiftPending = 1;
        shiftCount++;
        if (shiftCount == 1) firstShift = cyc;
        lastShift = cyc;
      end
      if (outStream.outValid && readyDrv) rxQ.push_back({outStream.outLast, outStream.outData});
      if (done) begin
        doneCount++;
        doneCycle = cyc;
      end

      wasBusy = mBusy;
      popM    = expValid && readyDrv;
      newDone = 0;
      if (mBusy && mPushed < ROWS && mQ.size() == DEPTH && mStall < 65535) mStall++;
      if (popM) void'(mQ.pop_front());
      if (expEn) begin
        mQ.push_back({1'(mPushed == ROWS - 1), colIn});
        mPushed++;
      end
      if (mBusy && popM && mPushed == ROWS && mQ.size() == 0) begin
        mBusy   = 0;
        newDone = 1;
      end
      if (!wasBusy && start) begin
        mBusy   = 1;
        mPushed = 0;
        mStall  = 0;
      end
      mDone = newDone;
    end
  end

  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clock);
    #1;
    start    = s;
    readyDrv = r;
  endtask

  task automatic preload();
    for (int i = 0; i < ROWS; i++) col[i] = W'(i + 1);
  endtask

  task automatic resetModel();
    mQ.delete();
    rxQ.delete();
    mBusy = 0; mDone = 0; mPushed = 0; mStall = 0;
    shiftPending = 0; prevStall = 0;
    doneCount = 0; shiftCount = 0;
  endtask

  task automatic startDrain(input logic r);
    rxQ.delete();
    doneCount  = 0;
    shiftCount = 0;
    applyStimulus(1'b1, r);
    startCyc = cyc;
  endtask

  // mode 0: outReady held high; mode 1: outReady toggles every cycle starting low.
  task automatic waitDone(input int mode, input string tag);
    logic r;
    r = 1'b1;
    for (int k = 0; k < 80 && doneCount == 0; k++) begin
      if (mode == 1) r = (k % 2 == 1);
      applyStimulus(1'b0, r);
    end
    if (doneCount == 0) checkOutput({tag, "_doneTimeout"}, 32'd0, 32'd1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic checkWords(input string tag);
    checkOutput({tag, "_wordCount"}, 32'(rxQ.size()), 32'(ROWS));
    for (int i = 0; i < ROWS && i < rxQ.size(); i++) begin
      checkOutput({tag, "_word"}, 32'(rxQ[i][W-1:0]), 32'(i + 1));
      checkOutput({tag, "_last"}, 32'(rxQ[i][W]), 32'(i == ROWS - 1));
    end
    checkOutput({tag, "_doneCount"}, 32'(doneCount), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_enable"}, 32'(enableShiftOut), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_valid"}, 32'(outStream.outValid), 32'd0);
    checkOutput({tag, "_last"}, 32'(outStream.outLast), 32'd0);
    checkOutput({tag, "_data"}, 32'(outStream.outData), 32'd0);
    checkOutput({tag, "_topCIn"}, 32'(topCIn), 32'd0);
  endtask

  initial begin
    cyc = 0;
    checkOn = 0;
    preload();
    resetModel();
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    reset   = 1'b0;
    checkOn = 1;

    // Scenario 1: free-flowing drain.
    preload();
    startDrain(1'b1);
    waitDone(0, "s1");
    checkWords("s1");
    checkOutput("s1_doneLatency", 32'(doneCycle - startCyc), 32'd10);
    checkOutput("s1_shiftCount", 32'(shiftCount), 32'd8);
    checkOutput("s1_firstShift", 32'(firstShift - startCyc), 32'd1);
    checkOutput("s1_shiftSpan", 32'(lastShift - firstShift), 32'd7);

    // Scenario 2: downstream blocked until the FIFO fills.
    preload();
    startDrain(1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0);
    checkOutput("s2_shiftCount", 32'(shiftCount), 32'd4);
    checkOutput("s2_enableStalled", 32'(enableShiftOut), 32'd0);
    checkOutput("s2_colBottom", 32'(col[0]), 32'd5);
    checkOutput("s2_colRow3", 32'(col[3]), 32'd8);
    checkOutput("s2_colRow4", 32'(col[4]), 32'd0);
    waitDone(0, "s2");
    checkWords("s2");

    // Scenario 3: outReady toggling.
    preload();
    startDrain(1'b0);
    waitDone(1, "s3");
    checkWords("s3");
    checkOutput("s3_busyAfterDone", 32'(busy), 32'd0);

    // Scenario 4: start pulses mid-drain and on the final pop are ignored.
    preload();
    startDrain(1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    waitDone(0, "s4");
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkWords("s4");
    checkOutput("s4_doneLatency", 32'(doneCycle - startCyc), 32'd10);
    checkOutput("s4_busyIdle", 32'(busy), 32'd0);

    // Scenario 5: asynchronous reset during the third shift cycle.
    preload();
    startDrain(1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("s5_enableBeforeReset", 32'(enableShiftOut), 32'd1);
    #2;
    checkOn = 0;
    reset   = 1'b1;
    #1;
    checkAllZero("s5_midReset");
    resetModel();
    applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
    preload();
    checkOn = 1;
    startDrain(1'b1);
    waitDone(0, "s5");
    checkWords("s5");

`ifdef SYSTOLIC_DRAIN_STALL_CNT_EN
    // Scenario 6: ten DRAIN cycles with the FIFO full, then a fresh start clears the counter.
    preload();
    startDrain(1'b0);
    repeat (13) applyStimulus(1'b0, 1'b0);
    waitDone(0, "s6");
    checkWords("s6");
    checkOutput("s6_stallCycles", 32'(stallCycles), 32'd10);
    preload();
    startDrain(1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("s6_stallCleared", 32'(stallCycles), 32'd0);
    waitDone(0, "s6b");
    checkWords("s6b");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
